noc_adaptive_route_selector: RTL
================================

# noc_adaptive_route_selector

Per-router route selector for the 2D-mesh NoC, the next generation of the XY/YX route selector. For every input virtual channel it computes the output port from the head flit, locks that route for the rest of the packet, and steers flits through a per-channel demux into per-port VC mergers. It adds west-first minimal adaptive routing driven by per-port congestion hints, and an explicit drop-to-local path for out-of-mesh destinations. It sits between the input VC buffers and the output-port arbiters inside `noc_router`.

## Interface
- CONFIG, NOC_DEFAULT_CONFIG: NoC configuration. Supplies size_x, size_y and virtual_channels.
- X, 0: this router's x coordinate.
- Y, 0: this router's y coordinate.
- AVAILABLE_PORTS, 5'b11111: port mask, bit order X+, X-, Y+, Y-, LOCAL.
- CHANNELS (localparam): CONFIG.virtual_channels.
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- flit_in_if  noc_flit_if.target  [CHANNELS]  input VC flits.
- flit_out_if  noc_flit_if.initiator  [5]  per-port merged flits.
- port_control_if  noc_port_control_if.requester  [5]  request/free/start_of_packet/end_of_packet per VC; grant returned.
- i_congested  in  5  per-port congestion hint. Bit n=1 means port n is congested. Sampled only at head-flit cycles.

## Operation
- Routing modes come from header.routing_mode: NOC_X_Y_ROUTING, NOC_Y_X_ROUTING, NOC_WEST_FIRST_ROUTING.
- Productive directions, masked by AVAILABLE_PORTS:
  - X+ when dest.x > X; X- when dest.x < X.
  - Y+ when dest.y > Y; Y- when dest.y < Y.
  - No productive direction selects LOCAL.
- XY mode: X directions take priority over Y. YX mode: Y directions take priority over X.
- West-first mode:
  - If X- is productive, the route is X- (deterministic).
  - Otherwise, with both an X+ and a Y candidate:
    - Pick the one whose i_congested bit is 0.
    - If both are congested or both are uncongested, use the per-channel 1-bit tie-break pointer: 0 selects X, 1 selects Y. The pointer toggles after every tie decision.
  - A single candidate is always taken.
- Invalid destination (dest.x >= size_x or dest.y >= size_y):
  - Header flits get invalid_destination = 1.
  - Route forced to LOCAL regardless of mode.
- Per-channel FSM, two states:
  - IDLE: route = combinational decision when the head flit is valid, else ROUTE_NA.
  - IDLE to BUSY: head accepted (valid & ready) and not tail. The decision is stored in route_q.
  - BUSY: route = route_q.
  - BUSY to IDLE: tail accepted.
  - Single-flit packet (head and tail, accepted): stays IDLE, route_q unchanged.
  - Head valid but not ready: stays IDLE. The decision is recomputed each cycle and may change with i_congested until acceptance.
  - A head flit in BUSY is a protocol error: it is ignored for routing and forwarded on route_q.
- port_control_if[j], for channel i with route[j] set:
  - request = valid; free = ready.
  - start_of_packet = head & valid; end_of_packet = tail & valid & ready.
  - All four are 0 otherwise, and always 0 for masked ports.
- Masked ports: flit_out_if valid and flit tied to 0; ready and vc_available toward the demux tied to 0.

## Timing
- Zero-cycle route latency: the head flit is steered in the cycle it is presented.
- Body and tail use the registered route.
- Reset values: FSM IDLE; route_q = ROUTE_NA; tie-break pointer = 0.
- After reset, all flit_out_if.valid and all port_control_if outputs are 0 until inputs are valid.
- Reset asserted mid-packet: returns to IDLE immediately. The remaining body flits then see route NA and are not forwarded (request 0). Upstream is also reset.
- One packet at a time per VC. Up to CHANNELS packets are in flight concurrently across VCs.

## Configuration
- NOC_ADAPTIVE_ROUTING_EN defined: west-first mode, the i_congested logic and the tie-break pointers are built.
- Not defined: NOC_WEST_FIRST_ROUTING headers are routed as XY, i_congested is unused, and no tie-break flops exist.

## Structure
- noc_config_pkg holds:
  - the e_route one-hot enum (X+=00001, X-=00010, Y+=00100, Y-=01000, LOCAL=10000, NA=00000);
  - the extended noc_routing_mode with NOC_WEST_FIRST_ROUTING.
- One sub-module, noc_route_channel: per-VC decision logic, FSM, route_q and tie-break pointer. Outputs the e_route vector and the patched flit.
- The top level instantiates CHANNELS noc_route_channel, existing noc_flit_if_demux per VC, and noc_vc_merger per available port.

## Test plan
- XY, router (1,1), dest (3,0), single VC: head on X+, body on X+. end_of_packet[0] on port 0 at tail accept; next cycle route NA.
- YX, same packet: routed Y- (port 3); X+ never requested.
- West-first, router (1,1), dest (3,3):
  - i_congested=00001 → Y+.
  - i_congested=00000 on two successive packets → X+ then Y+ (pointer toggles).
  - dest (0,3) with i_congested=00010 → still X-.
- Dest (9,0) in a 4x4 mesh: routed LOCAL with invalid_destination=1 in the output header.
- Head held with ready=0 for 3 cycles while i_congested changes: route follows until acceptance, then stays fixed for the 4-flit body despite changes.
- Reset asserted in BUSY after flit 2 of 4: the route clears; the next head routes fresh. With NOC_ADAPTIVE_ROUTING_EN undefined, a west-first header to (3,3) from (1,1) goes X+.

Source files
------------

// File: rtl/noc_adaptive_route_selector_pkg.sv
// Shared NoC types: mesh config, routing modes, one-hot output routes, flit/header layout.
// Pure type/constant package; no logic, no latency, no flow control.
package noc_config_pkg;

  typedef struct packed {
    int size_x;
    int size_y;
    int virtual_channels;
  } noc_cfg_t;

  localparam noc_cfg_t NOC_DEFAULT_CONFIG = '{size_x: 4, size_y: 4, virtual_channels: 2};

  typedef enum logic [1:0] {
    NOC_X_Y_ROUTING        = 2'd0,
    NOC_Y_X_ROUTING        = 2'd1,
    NOC_WEST_FIRST_ROUTING = 2'd2
  } noc_routing_mode;

  // Bit n of the one-hot route is output port n (X+, X-, Y+, Y-, LOCAL).
  typedef enum logic [4:0] {
    ROUTE_NA      = 5'b00000,
    ROUTE_X_PLUS  = 5'b00001,
    ROUTE_X_MINUS = 5'b00010,
    ROUTE_Y_PLUS  = 5'b00100,
    ROUTE_Y_MINUS = 5'b01000,
    ROUTE_LOCAL   = 5'b10000
  } e_route;

  typedef struct packed {
    noc_routing_mode routing_mode;
    logic            invalid_destination;
    logic [3:0]      dest_x;
    logic [3:0]      dest_y;
    logic [20:0]     payload;
  } hdr_t;

  typedef struct packed {
    logic        head;
    logic        tail;
    logic [31:0] data;
  } flit_t;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_BUSY = 1'b1
  } chan_state_e;

  function automatic e_route prefer(input e_route first, input e_route second);
    if (first != ROUTE_NA) return first;
    if (second != ROUTE_NA) return second;
    return ROUTE_LOCAL;
  endfunction

endpackage

// File: rtl/noc_adaptive_route_selector_channel.sv
// Per-VC route decision, packet route lock and west-first tie-break (NOC_ADAPTIVE_ROUTING_EN).
// Head routed combinationally in its own cycle; body/tail use the locked route; state advances only on valid&ready.
module noc_route_channel
  import noc_config_pkg::*;
#(
  parameter noc_cfg_t   CONFIG          = NOC_DEFAULT_CONFIG,
  parameter int         X               = 0,
  parameter int         Y               = 0,
  parameter logic [4:0] AVAILABLE_PORTS = 5'b11111
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid,
  input  logic       ready,
  input  flit_t      flit,
  input  logic [4:0] congested,
  output e_route     route,
  output flit_t      flit_patched
);

  chan_state_e state_q, state_d;
  e_route      route_q, route_d;
  e_route      decision, x_cand, y_cand;
  hdr_t        hdr, hdr_marked;
  logic        invalid_dest;
  logic        accept;

  assign hdr          = hdr_t'(flit.data);
  assign accept       = valid & ready;
  assign invalid_dest = (int'(hdr.dest_x) >= CONFIG.size_x) || (int'(hdr.dest_y) >= CONFIG.size_y);

  always_comb begin
    hdr_marked = hdr;
    hdr_marked.invalid_destination = 1'b1;
  end

  always_comb begin
    x_cand = ROUTE_NA;
    y_cand = ROUTE_NA;
    if (int'(hdr.dest_x) > X && AVAILABLE_PORTS[0])      x_cand = ROUTE_X_PLUS;
    else if (int'(hdr.dest_x) < X && AVAILABLE_PORTS[1]) x_cand = ROUTE_X_MINUS;
    if (int'(hdr.dest_y) > Y && AVAILABLE_PORTS[2])      y_cand = ROUTE_Y_PLUS;
    else if (int'(hdr.dest_y) < Y && AVAILABLE_PORTS[3]) y_cand = ROUTE_Y_MINUS;
  end

`ifdef NOC_ADAPTIVE_ROUTING_EN
  logic ptr_q, ptr_d;
  logic tie;
  logic x_cong, y_cong;

  assign x_cong = congested[0];
  assign y_cong = |(congested & y_cand);
`else
  logic unused_congested;
  assign unused_congested = ^congested;
`endif

  always_comb begin
    decision = prefer(x_cand, y_cand);
`ifdef NOC_ADAPTIVE_ROUTING_EN
    tie = 1'b0;
`endif
    if (invalid_dest) begin
      decision = ROUTE_LOCAL;
    end else begin
      case (hdr.routing_mode)
        NOC_Y_X_ROUTING: decision = prefer(y_cand, x_cand);
`ifdef NOC_ADAPTIVE_ROUTING_EN
        NOC_WEST_FIRST_ROUTING: begin
          // West moves are never adaptive; single candidates fall through to the XY default.
          if (x_cand == ROUTE_X_MINUS) begin
            decision = ROUTE_X_MINUS;
          end else if (x_cand == ROUTE_X_PLUS && y_cand != ROUTE_NA) begin
            if (x_cong != y_cong) begin
              decision = x_cong ? y_cand : ROUTE_X_PLUS;
            end else begin
              tie      = 1'b1;
              decision = ptr_q ? y_cand : ROUTE_X_PLUS;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    route_d      = route_q;
    route        = ROUTE_NA;
    flit_patched = flit;
`ifdef NOC_ADAPTIVE_ROUTING_EN
    ptr_d        = ptr_q;
`endif
    case (state_q)
      CH_IDLE: begin
        if (valid && flit.head) begin
          route = decision;
          if (invalid_dest) flit_patched.data = hdr_marked;
          if (accept) begin
            if (!flit.tail) begin
              state_d = CH_BUSY;
              route_d = decision;
            end
`ifdef NOC_ADAPTIVE_ROUTING_EN
            if (tie) ptr_d = ~ptr_q;
`endif
          end
        end
      end
      CH_BUSY: begin
        // A stray head here is forwarded on the locked route, never re-decided.
        route = route_q;
        if (accept && flit.tail) state_d = CH_IDLE;
      end
      default: state_d = CH_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CH_IDLE;
      route_q <= ROUTE_NA;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
    end
  end

`ifdef NOC_ADAPTIVE_ROUTING_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end
`endif

endmodule

// File: rtl/noc_adaptive_route_selector.sv
// Router route selector: per-VC route channels, flit demux and per-port VC merge; west-first under NOC_ADAPTIVE_ROUTING_EN.
// Zero-cycle head steering; VC ready = downstream ready & grant of the routed port; masked ports tied off.
module noc_adaptive_route_selector
  import noc_config_pkg::*;
#(
  parameter noc_cfg_t   CONFIG          = NOC_DEFAULT_CONFIG,
  parameter int         X               = 0,
  parameter int         Y               = 0,
  parameter logic [4:0] AVAILABLE_PORTS = 5'b11111,
  localparam int        CHANNELS        = CONFIG.virtual_channels,
  localparam int        VCW             = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CHANNELS-1:0]      flit_in_valid,
  output logic [CHANNELS-1:0]      flit_in_ready,
  input  flit_t                    flit_in [CHANNELS],
  output logic [4:0]               flit_out_valid,
  input  logic [4:0][CHANNELS-1:0] flit_out_ready,
  output flit_t                    flit_out [5],
  output logic [4:0][VCW-1:0]      flit_out_vc,
  output logic [4:0][CHANNELS-1:0] port_request,
  output logic [4:0][CHANNELS-1:0] port_free,
  output logic [4:0][CHANNELS-1:0] port_start_of_packet,
  output logic [4:0][CHANNELS-1:0] port_end_of_packet,
  input  logic [4:0][CHANNELS-1:0] port_grant,
  input  logic [4:0]               i_congested
);

  e_route                   route     [CHANNELS];
  flit_t                    chan_flit [CHANNELS];
  logic [4:0][CHANNELS-1:0] port_valid;
  logic [4:0][CHANNELS-1:0] port_ready;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic [4:0] route_bits;
    logic [4:0] ready_bits;

    noc_route_channel #(
      .CONFIG         (CONFIG),
      .X              (X),
      .Y              (Y),
      .AVAILABLE_PORTS(AVAILABLE_PORTS)
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .valid       (flit_in_valid[i]),
      .ready       (flit_in_ready[i]),
      .flit        (flit_in[i]),
      .congested   (i_congested),
      .route       (route[i]),
      .flit_patched(chan_flit[i])
    );

    assign route_bits       = route[i];
    assign flit_in_ready[i] = |(route_bits & ready_bits);

    for (genvar p = 0; p < 5; p++) begin : g_port
      assign port_ready[p][i]           = AVAILABLE_PORTS[p] & flit_out_ready[p][i] & port_grant[p][i];
      assign ready_bits[p]              = port_ready[p][i];
      assign port_valid[p][i]           = AVAILABLE_PORTS[p] & route_bits[p] & flit_in_valid[i];
      assign port_request[p][i]         = port_valid[p][i];
      assign port_free[p][i]            = AVAILABLE_PORTS[p] & route_bits[p] & flit_in_ready[i];
      assign port_start_of_packet[p][i] = port_valid[p][i] & flit_in[i].head;
      assign port_end_of_packet[p][i]   = port_valid[p][i] & flit_in[i].tail & flit_in_ready[i];
    end
  end

  for (genvar p = 0; p < 5; p++) begin : g_merge
    if (AVAILABLE_PORTS[p]) begin : g_on
      logic           m_valid;
      flit_t          m_flit;
      logic [VCW-1:0] m_vc;

      // The output arbiter grants one VC at a time; lowest index wins if it ever grants several.
      always_comb begin
        m_valid = 1'b0;
        m_flit  = '0;
        m_vc    = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
          if (port_valid[p][i] && port_grant[p][i]) begin
            m_valid = 1'b1;
            m_flit  = chan_flit[i];
            m_vc    = VCW'(i);
          end
        end
      end

      assign flit_out_valid[p] = m_valid;
      assign flit_out[p]       = m_flit;
      assign flit_out_vc[p]    = m_vc;
    end else begin : g_off
      assign flit_out_valid[p] = 1'b0;
      assign flit_out[p]       = '0;
      assign flit_out_vc[p]    = '0;
    end
  end

endmodule
